// File: rtl/display_pkg.sv
// Shared display-path definitions: coordinate width, screen limits and the
// line arbiter's state encoding.
package display_pkg;
  localparam int CW       = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    DRAW,
    ACK
  } arb_state_t;
endpackage

// File: rtl/line_arbiter_if.sv
// Bundle between the line arbiter, its drawing clients, the line_drawer and
// the framebuffer write path. master = arbiter side, slave = surroundings.
interface line_arbiter_if
  import display_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int CW   = display_pkg::CW,
  parameter int COLW = 1
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][CW-1:0]   req_x0;
  logic [NREQ-1:0][CW-1:0]   req_y0;
  logic [NREQ-1:0][CW-1:0]   req_x1;
  logic [NREQ-1:0][CW-1:0]   req_y1;
  logic [NREQ-1:0][COLW-1:0] req_color;
  logic [NREQ-1:0]           ack;
  logic                      err;
  logic                      busy;
  logic [IW-1:0]             owner;
  logic                      ld_start;
  logic [CW-1:0]             ld_x0, ld_y0, ld_x1, ld_y1;
  logic [CW-1:0]             ld_x, ld_y;
  logic                      ld_drawn;
  logic [CW-1:0]             pix_x, pix_y;
  logic [COLW-1:0]           pix_color;
  logic                      pix_we;

  modport master (
    input  req, req_x0, req_y0, req_x1, req_y1, req_color,
    input  ld_x, ld_y, ld_drawn,
    output ack, err, busy, owner,
    output ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
    output pix_x, pix_y, pix_color, pix_we
  );

  modport slave (
    output req, req_x0, req_y0, req_x1, req_y1, req_color,
    output ld_x, ld_y, ld_drawn,
    input  ack, err, busy, owner,
    input  ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
    input  pix_x, pix_y, pix_color, pix_we
  );
endinterface

// File: rtl/line_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request after the last
// granted index, wrapping modulo NREQ.
module rr_picker #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);
  int            w_cand;
  logic [IW-1:0] w_cidx;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    w_cidx  = '0;
    // k = NREQ lands back on i_last itself, so it is considered last
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = int'(i_last) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      w_cidx = IW'(w_cand);
      if (!o_valid && i_req[w_cidx]) begin
        o_valid = 1'b1;
        o_idx   = w_cidx;
      end
    end
  end
endmodule

// File: rtl/line_arbiter.sv
// Shares one line_drawer between NREQ clients: grants round-robin, restarts the
// drawer, streams its pixels to the framebuffer and acks the owner on completion.
module line_arbiter
  import display_pkg::*;
#(
  parameter  int NREQ    = 3,
  parameter  int CW      = display_pkg::CW,
  parameter  int COLW    = 1,
  parameter  int TIMEOUT = 2048,
  localparam int IW      = $clog2(NREQ),
  localparam int CNTW    = $clog2(TIMEOUT)
) (
  input  logic           clk,
  input  logic           reset,
  line_arbiter_if.master bus
);
  arb_state_t      r_state, w_state_next;
  logic [IW-1:0]   r_owner, r_rr;
  logic [CW-1:0]   r_x0, r_y0, r_x1, r_y1;
  logic [COLW-1:0] r_color;
  logic [CNTW-1:0] r_cnt;
  logic            r_err;
  logic            r_ld_start;
  logic            w_grant_vld;
  logic [IW-1:0]   w_grant_idx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req   (bus.req),
    .i_last  (r_rr),
    .o_valid (w_grant_vld),
    .o_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_next = LOAD;
      LOAD:    w_state_next = SETTLE;
      // ld_drawn may still be high from the previous line here
      SETTLE:  w_state_next = DRAW;
      DRAW:    if (bus.ld_drawn || r_cnt == CNTW'(TIMEOUT - 1)) w_state_next = ACK;
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr       <= IW'(NREQ - 1);
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_color    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_ld_start <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_ld_start <= (w_state_next == LOAD);
      if (r_state == IDLE && w_grant_vld) begin
        r_owner <= w_grant_idx;
        r_x0    <= bus.req_x0[w_grant_idx];
        r_y0    <= bus.req_y0[w_grant_idx];
        r_x1    <= bus.req_x1[w_grant_idx];
        r_y1    <= bus.req_y1[w_grant_idx];
        r_color <= bus.req_color[w_grant_idx];
      end
      if (r_state == SETTLE) r_cnt <= '0;
      else if (r_state == DRAW) r_cnt <= r_cnt + 1'b1;
      // Value on the final DRAW cycle tells whether the line ended by timeout
      if (r_state == DRAW) r_err <= !bus.ld_drawn;
      if (r_state == ACK) r_rr <= r_owner;
    end
  end

  always_comb begin
    bus.ack    = '0;
    bus.err    = 1'b0;
    bus.busy   = (r_state != IDLE);
    bus.pix_we = 1'b0;
    bus.pix_x  = '0;
    bus.pix_y  = '0;
    case (r_state)
      DRAW: begin
        bus.pix_we = 1'b1;
        bus.pix_x  = bus.ld_x;
        bus.pix_y  = bus.ld_y;
      end
      ACK: begin
        bus.ack = NREQ'(1) << r_owner;
        bus.err = r_err;
      end
      default: ;
    endcase
  end

  assign bus.owner     = r_owner;
  assign bus.ld_start  = r_ld_start;
  assign bus.ld_x0     = r_x0;
  assign bus.ld_y0     = r_y0;
  assign bus.ld_x1     = r_x1;
  assign bus.ld_y1     = r_y1;
  assign bus.pix_color = r_color;
endmodule

// File: doc/line_arbiter.md
Name: line_arbiter

Overview:
- Shares the single `line_drawer` instance between up to NREQ independent drawing clients, e.g. board-grid drawer, falling-piece drawer and row-clear eraser.
- Latches one client's endpoints and colour, then pulses the drawer's start/reset input.
- Forwards the drawer's pixel stream with a write-enable to the VGA framebuffer path.
- Returns a one-cycle acknowledge to the owning client when the line completes, or when a watchdog timeout expires.

Parameters:
- NREQ, 3, number of requesting clients (2..8).
- CW, 11, coordinate width in bits; matches the 11-bit x/y used throughout the display path.
- COLW, 1, pixel colour width (1 = on/off).
- TIMEOUT, 2048, maximum DRAW cycles before forced abort; must exceed the longest 640x480 line.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- req  input  NREQ  per-client request; level, held until ack.
- req_x0, req_y0, req_x1, req_y1  input  NREQ x CW each  per-client endpoints.
- req_color  input  NREQ x COLW  per-client colour.
- ack  output  NREQ  one-hot, one-cycle completion pulse to the owner.
- err  output  1  one-cycle pulse coincident with ack when the line was aborted by timeout.
- busy  output  1  high in any state other than IDLE.
- owner  output  $clog2(NREQ)  index of the current/last granted client.
- ld_start  output  1  drives `line_drawer` .reset; high restarts the drawer.
- ld_x0, ld_y0, ld_x1, ld_y1  output  CW each  latched endpoints to the drawer.
- ld_x, ld_y  input  CW each  current pixel from the drawer.
- ld_drawn  input  1  drawer's line-complete flag.
- pix_x, pix_y  output  CW each  pixel address to the framebuffer.
- pix_color  output  COLW  latched colour.
- pix_we  output  1  framebuffer write-enable.

Behaviour:
- Reset values (reset==0 at a clk edge):
  - state=IDLE, ack=0, err=0, busy=0, owner=0, rr pointer=NREQ-1, pix_we=0.
  - ld_start=1, holding the drawer in reset; latched coords and colour = 0.
  - Reset mid-line abandons the line with no ack; clients must re-request.
- FSM states: IDLE, LOAD, SETTLE, DRAW, ACK.
- IDLE:
  - If any req is high, grant round-robin: search indices rr+1, rr+2, ... modulo NREQ; the first high req wins.
  - On grant: latch that client's x0/y0/x1/y1/color into ld_* and pix_color, set owner, go LOAD.
  - With no req, stay in IDLE with ld_start=0.
- LOAD: ld_start=1 for exactly this one cycle; go SETTLE.
- SETTLE: ld_start=0; ld_drawn is ignored because it may be stale from the previous line; clear the watchdog counter; go DRAW.
- DRAW:
  - pix_we=1, pix_x=ld_x, pix_y=ld_y (combinational pass-through), so every pixel including the last one is written.
  - Watchdog counter increments each cycle.
  - If ld_drawn=1, go ACK with err_next=0.
  - Else if counter==TIMEOUT-1, go ACK with err_next=1.
- ACK:
  - pix_we=0; ack[owner]=1 for one cycle; err=err_next; rr<=owner; go IDLE.
  - Earliest next grant is the following cycle.
- Per-line overhead: 4 cycles (IDLE grant, LOAD, SETTLE, ACK) plus the DRAW cycles.
- Requests and coordinates are sampled only at grant:
  - Changing req_* or dropping req of the owner mid-line has no effect; the line completes and ack is still issued.
  - A client still asserting req in the cycle after its ack is treated as a new request.
- Fairness: a client granted at line k cannot be granted at line k+1 while any other req is high.
- Degenerate line (x0==x1, y0==y1): handled normally; it is drawn as whatever the drawer emits, at least 1 pixel.
- Outside DRAW: pix_x/pix_y = 0 and pix_we = 0.

Decomposition:
- Shared package `display_pkg`:
  - CW constant (11).
  - Screen limits 640/480.
  - `arb_state_t` enum {IDLE, LOAD, SETTLE, DRAW, ACK}.
- Natural sub-module: `rr_picker`, a combinational round-robin selector (req vector + last pointer -> grant valid + index).
- `line_drawer` is instantiated by the parent alongside `line_arbiter`, not inside it.

Test Plan:
- Single request: client 1 requests (10,20)->(30,20), colour 1; drawer model asserts drawn after 21 pixels.
  - Expect ld_start high exactly 1 cycle.
  - Expect 21 pix_we cycles with pix_x 10..30, pix_y=20.
  - Expect ack=3'b010 one cycle; err=0; owner=1.
- Contention: req=3'b111 held continuously after reset.
  - Expect grant order 0,1,2,0,1,2.
  - Expect no back-to-back grants to the same client.
  - Expect acks strictly one-hot and never overlapping.
- Stale drawn: drawer model holds ld_drawn=1 through LOAD/SETTLE before dropping.
  - Expect the arbiter still enters DRAW.
  - Expect no ack until ld_drawn re-asserts.
- Timeout: drawer model never asserts drawn, TIMEOUT=16.
  - Expect exactly 16 pix_we cycles.
  - Expect ack and err pulsed together; FSM returns to IDLE.
- Mid-line changes: requester changes req_x1 and drops req during DRAW.
  - Expect ld_x1 unchanged and ack still pulsed.
- Reset mid-DRAW: reset=0 for 1 cycle.
  - Next cycle expect busy=0, ld_start=1, pix_we=0, ack=0.
  - After reset=1, the pending req is re-granted starting from index 0.
